data_cache: RTL and testbench
=============================

# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipelined CPU's MEM stage and a line-wide backing memory. Responds to single-word CPU load/store requests with a valid/ready handshake and a one-cycle hit path. Issues whole-line writebacks and refills to the backing memory on misses. The CPU stalls its pipeline while `ready` is low.

## Interface
- `SETS`, 16, number of lines; power of two.
- `LINE_WORDS`, 4, 32-bit words per line; power of two.
- `clk`  in  1  clock, all state updates on rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  CPU request present.
- `req_write`  in  1  1 = store, 0 = load.
- `req_addr`  in  32  byte address; bits [1:0] ignored.
- `req_wdata`  in  32  store data.
- `ready`  out  1  cache idle, accepts request this cycle.
- `resp_valid`  out  1  one-cycle pulse, request complete.
- `resp_rdata`  out  32  load data (store: the written word).
- `resp_hit`  out  1  qualifies `resp_valid`; 1 if first lookup hit.
- `mem_req_valid`  out  1  backing-memory request.
- `mem_req_write`  out  1  1 = line writeback, 0 = line refill.
- `mem_req_addr`  out  32  line-aligned byte address.
- `mem_req_wdata`  out  32*LINE_WORDS  writeback line, word 0 in LSBs.
- `mem_req_ready`  in  1  backing memory accepts request.
- `mem_resp_valid`  in  1  refill data valid (reads only).
- `mem_resp_rdata`  in  32*LINE_WORDS  refill line.

## Operation
- Address split: offset = [OB+1:2], OB = log2(LINE_WORDS); index = next log2(SETS) bits; tag = remaining upper bits.
- Per line: valid, dirty, tag, data. Reset clears all valid and dirty bits; data/tag contents are don't-care.
- States: IDLE, LOOKUP, WRITEBACK, REFILL_REQ, REFILL_WAIT.
- IDLE: `ready`=1. On `req_valid`, latch write, addr, wdata; go LOOKUP. `req_valid` with `ready`=0 is ignored; the CPU holds the request until accepted.
- LOOKUP: hit = valid & tag match.
  - Hit, load: `resp_valid`=1, `resp_rdata`=word[offset]; go IDLE.
  - Hit, store: write word[offset], set dirty, `resp_valid`=1; go IDLE.
  - Miss, victim valid & dirty: go WRITEBACK.
  - Miss, otherwise: go REFILL_REQ.
  - Clear a per-request `first_miss` flag on any miss.
- WRITEBACK: `mem_req_valid`=1, `mem_req_write`=1, addr = {victim tag, index, 0}, wdata = victim line. On `mem_req_ready`, clear dirty and go REFILL_REQ.
- REFILL_REQ: `mem_req_valid`=1, `mem_req_write`=0, addr = {req tag, index, 0}. On `mem_req_ready`, go REFILL_WAIT.
- REFILL_WAIT: on `mem_resp_valid`, write the line, set valid=1, dirty=0, set the new tag; go LOOKUP. The replay hits and completes the request.
- `resp_hit` = 1 only if no miss occurred for the current request.
- `mem_req_*` outputs are held stable while `mem_req_valid`=1 and `mem_req_ready`=0.

## Timing
- Reset values: state IDLE, `ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_hit`=0, `mem_req_valid`=0, `mem_req_write`=0, `mem_req_addr`=0, `mem_req_wdata`=0.
- Hit latency: request accepted at edge N; `resp_valid` high during cycle N+1; `ready` high again in cycle N+2.
- Clean miss latency: 1 (lookup) + handshake + memory latency + 1 (replay).
- Dirty miss adds one writeback handshake first.
- `mem_resp_valid` outside REFILL_WAIT is ignored.
- `mem_req_ready` and `mem_resp_valid` may both be high in the same cycle; only the current state's condition is acted on.
- Reset mid-operation: return to IDLE at that edge and drop `mem_req_valid`. The backing memory shares `reset`, so no outstanding transaction survives.
- Index wrap-around: addresses 0x000 and SETS*LINE_WORDS*4 share a set and conflict.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_count` (32) and `miss_count` (32), both reset to 0.
  - Each increments once per completed request according to `resp_hit`.
  - Both wrap at 2^32.
- `DCACHE_STATS_EN` undefined: the counters and ports do not exist; behaviour is otherwise identical.

## Test plan
- Cold load from 0x100, memory line = {4,3,2,1}, ready after 1 cycle, response 3 cycles later -> one refill request at 0x100; `resp_rdata`=1, `resp_hit`=0.
- Load from 0x104 immediately after -> `resp_valid` the cycle after acceptance; `resp_rdata`=2, `resp_hit`=1; no memory request.
- Store 0xDEADBEEF to 0x108, then load 0x500 (same index, different tag) -> writeback to 0x100 with word2=0xDEADBEEF, then refill at 0x500.
- Load 0x100 again -> clean refill; `resp_rdata`=1; the line is not written back.
- Assert `reset` during REFILL_WAIT -> next cycle `ready`=1, `mem_req_valid`=0, `resp_valid`=0. A subsequent load of 0x104 misses.
- With `DCACHE_STATS_EN`: 3 hits and 2 misses -> `hit_count`=3, `miss_count`=2; `reset` -> both 0.

Source files
------------

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Single-word CPU requests (valid/ready); line-wide writeback/refill to memory.
// Optional feature macro: DCACHE_STATS_EN adds hit_count/miss_count outputs.
// SETS and LINE_WORDS must be powers of two, each at least 2.
module data_cache #(
  parameter int SETS       = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  input  logic                      req_write,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  output logic                      ready,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_hit,
  output logic                      mem_req_valid,
  output logic                      mem_req_write,
  output logic [31:0]               mem_req_addr,
  output logic [32*LINE_WORDS-1:0]  mem_req_wdata,
  input  logic                      mem_req_ready,
  input  logic                      mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0]  mem_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]               hit_count,
  output logic [31:0]               miss_count
`endif
);

  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(SETS);
  localparam int TW = 32 - IB - OB - 2;

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_LOOKUP      = 3'd1;
  localparam logic [2:0] S_WRITEBACK   = 3'd2;
  localparam logic [2:0] S_REFILL_REQ  = 3'd3;
  localparam logic [2:0] S_REFILL_WAIT = 3'd4;

  logic [2:0]  state;
  logic        cur_write;
  logic [29:0] cur_word;   // word address of the latched request
  logic [31:0] cur_wdata;
  logic        clean_req;  // stays 1 until the current request misses

  logic [SETS-1:0]                 valid_bits;
  logic [SETS-1:0]                 dirty_bits;
  logic [TW-1:0]                   tag_mem  [SETS];
  logic [LINE_WORDS-1:0][31:0]     data_mem [SETS];

  logic [OB-1:0] cur_off;
  logic [IB-1:0] cur_idx;
  logic [TW-1:0] cur_tag;
  logic          hit;
  logic          lookup_hit;

  // Byte-lane bits of the address carry no meaning for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

  assign cur_off    = cur_word[OB-1:0];
  assign cur_idx    = cur_word[OB +: IB];
  assign cur_tag    = cur_word[29 -: TW];
  assign hit        = valid_bits[cur_idx] && (tag_mem[cur_idx] == cur_tag);
  assign lookup_hit = (state == S_LOOKUP) && hit;

  assign ready         = (state == S_IDLE);
  assign resp_valid    = lookup_hit;
  assign resp_hit      = lookup_hit && clean_req;
  assign mem_req_valid = (state == S_WRITEBACK) || (state == S_REFILL_REQ);
  assign mem_req_write = (state == S_WRITEBACK);

  // Response data: stored word on a store hit, cached word on a load hit.
  always_comb begin
    resp_rdata = '0;
    if (lookup_hit)
      resp_rdata = cur_write ? cur_wdata : data_mem[cur_idx][cur_off];
  end

  // Memory request address/data are pure functions of state and latched
  // request, so they hold steady for the whole handshake.
  always_comb begin
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (state == S_WRITEBACK) begin
      mem_req_addr  = {tag_mem[cur_idx], cur_idx, {(OB+2){1'b0}}};
      mem_req_wdata = data_mem[cur_idx];
    end else if (state == S_REFILL_REQ) begin
      mem_req_addr  = {cur_tag, cur_idx, {(OB+2){1'b0}}};
    end
  end

  // Controller FSM and request latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cur_write <= 1'b0;
      cur_word  <= '0;
      cur_wdata <= '0;
      clean_req <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (req_valid) begin
          cur_write <= req_write;
          cur_word  <= req_addr[31:2];
          cur_wdata <= req_wdata;
          clean_req <= 1'b1;
          state     <= S_LOOKUP;
        end
        S_LOOKUP: if (hit) begin
          state <= S_IDLE;
        end else begin
          clean_req <= 1'b0;
          state     <= (valid_bits[cur_idx] && dirty_bits[cur_idx]) ? S_WRITEBACK
                                                                    : S_REFILL_REQ;
        end
        S_WRITEBACK:   if (mem_req_ready)  state <= S_REFILL_REQ;
        S_REFILL_REQ:  if (mem_req_ready)  state <= S_REFILL_WAIT;
        S_REFILL_WAIT: if (mem_resp_valid) state <= S_LOOKUP;
        default:       state <= S_IDLE;
      endcase
    end
  end

  // Line status bits: dirty on store hit, clean after writeback or refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_bits <= '0;
      dirty_bits <= '0;
    end else begin
      if (lookup_hit && cur_write)
        dirty_bits[cur_idx] <= 1'b1;
      if (state == S_WRITEBACK && mem_req_ready)
        dirty_bits[cur_idx] <= 1'b0;
      if (state == S_REFILL_WAIT && mem_resp_valid) begin
        valid_bits[cur_idx] <= 1'b1;
        dirty_bits[cur_idx] <= 1'b0;
      end
    end
  end

  // Tag and data arrays; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (lookup_hit && cur_write)
        data_mem[cur_idx][cur_off] <= cur_wdata;
      if (state == S_REFILL_WAIT && mem_resp_valid) begin
        data_mem[cur_idx] <= mem_resp_rdata;
        tag_mem[cur_idx]  <= cur_tag;
      end
    end
  end

`ifdef DCACHE_STATS_EN
  // One count per completed request, classified by first-lookup outcome.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (lookup_hit) begin
      if (clean_req) hit_count  <= hit_count + 32'd1;
      else           miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: scoreboard bench for data_cache. Expected responses come from
// a flat word-memory reference plus a per-set residency table; a behavioural
// backing memory with random handshake/latency serves refills and absorbs
// writebacks, checking each writeback against the reference memory.
module tb_data_cache;
  localparam int SETS = 16;
  localparam int LW   = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]   req_addr = '0, req_wdata = '0;
  logic          ready, resp_valid, resp_hit;
  logic [31:0]   resp_rdata;
  logic          mem_req_valid, mem_req_write;
  logic [31:0]   mem_req_addr;
  logic [127:0]  mem_req_wdata;
  logic          mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
  logic [127:0]  mem_resp_rdata = '0;
`ifdef DCACHE_STATS_EN
  logic [31:0]   hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  data_cache #(.SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .ready(ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        hit;
    int          wb;
    int          rf;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0, bad = 0;
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] bmem    [logic [31:0]];
  logic        mvalid [SETS];
  logic        mdirty [SETS];
  logic [23:0] mtag   [SETS];
  logic [31:0] exp_wb_addr = '0, exp_rf_addr = '0;
  int          wb_cnt = 0, rf_cnt = 0, last_wb = 0, last_rf = 0;
  int          exp_hits = 0, exp_misses = 0;
  bit          hold = 1'b0;
  int          mst = 0, dly = 0, lat = 0;
  logic [31:0] rf_line = '0;
  exp_t        mon_e;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction
  function automatic logic [31:0] rd_ref(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return bmem.exists(a) ? bmem[a] : dflt(a);
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Backing memory: random accept delay, random refill latency, and junk
  // strobes on mem_resp_valid/mem_req_ready when the cache must ignore them.
  always @(negedge clk) begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    if (reset) begin
      mst = 0;
    end else if (mst == 0) begin
      if (mem_req_valid) begin
        if (dly > 0) dly--;
        else begin
          mem_req_ready = 1'b1;
          dly = $urandom_range(0, 2);
          if (mem_req_write) begin
            wb_cnt++;
            chk("wb_addr", mem_req_addr, exp_wb_addr);
            for (int w = 0; w < LW; w++) begin
              chk("wb_data", mem_req_wdata[32*w +: 32], rd_ref(mem_req_addr + 32'(4*w)));
              bmem[mem_req_addr + 32'(4*w)] = mem_req_wdata[32*w +: 32];
            end
          end else begin
            rf_cnt++;
            chk("rf_addr", mem_req_addr, exp_rf_addr);
            rf_line = mem_req_addr;
            lat = $urandom_range(0, 3);
            mst = 1;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = {4{32'hBADBAD00}};
        mem_req_ready  = 1'($urandom_range(0, 1));
      end
    end else begin
      mem_req_ready = 1'($urandom_range(0, 1));
      if (!hold) begin
        if (lat > 0) lat--;
        else begin
          mem_resp_valid = 1'b1;
          for (int w = 0; w < LW; w++)
            mem_resp_rdata[32*w +: 32] = rd_mem(rf_line + 32'(4*w));
          mst = 0;
        end
      end
    end
  end

  // Monitor: pops one expectation per response pulse.
  always @(negedge clk) begin
    if (reset) begin
      sbq.delete();
      last_wb = wb_cnt; last_rf = rf_cnt;
      exp_hits = 0; exp_misses = 0;
    end else if (resp_valid) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL spurious_resp: got resp_valid=1 want no response pending");
      end else begin
        mon_e = sbq.pop_front();
        chk("rdata", resp_rdata, mon_e.rdata);
        chk("hit", resp_hit, mon_e.hit);
        chk("wb_count", wb_cnt - last_wb, mon_e.wb);
        chk("rf_count", rf_cnt - last_rf, mon_e.rf);
        last_wb = wb_cnt; last_rf = rf_cnt;
        if (mon_e.hit) exp_hits++; else exp_misses++;
      end
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd);
    exp_t e; int idx; logic [23:0] tg; logic [31:0] wa; int n;
    wa = {a[31:2], 2'b00}; idx = int'(a[7:4]); tg = a[31:8];
    n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin @(negedge clk); n++; end
    if (!ready) begin
      total++; bad++;
      $display("FAIL ready_timeout: got ready=0 want 1 within 300 cycles");
      return;
    end
    e.hit = mvalid[idx] && (mtag[idx] == tg);
    e.wb  = (!e.hit && mvalid[idx] && mdirty[idx]) ? 1 : 0;
    e.rf  = e.hit ? 0 : 1;
    exp_wb_addr = {mtag[idx], 4'(idx), 4'h0};
    exp_rf_addr = {tg, 4'(idx), 4'h0};
    if (!e.hit) begin mvalid[idx] = 1'b1; mtag[idx] = tg; mdirty[idx] = 1'b0; end
    if (wr) begin mdirty[idx] = 1'b1; ref_mem[wa] = wd; e.rdata = wd; end
    else e.rdata = rd_ref(wa);
    sbq.push_back(e);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sbq.size());
      sbq.delete();
    end
    @(negedge clk); #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < SETS; i++) begin mvalid[i] = 1'b0; mdirty[i] = 1'b0; mtag[i] = '0; end
  endtask

  initial begin
    int n;
    clear_model();
    for (int w = 0; w < LW; w++) begin
      bmem[32'h100 + 32'(4*w)]    = 32'(w + 1);
      ref_mem[32'h100 + 32'(4*w)] = 32'(w + 1);
    end
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_hit", resp_hit, 1'b0);
    chk("rst_mem_req", {mem_req_valid, mem_req_write, mem_req_addr}, 34'h0);
    chk("rst_mem_wdata", mem_req_wdata, 128'h0);
    reset = 1'b0;

    // Directed: cold miss, hit, store, dirty eviction, clean refill, wrap conflict.
    do_req(1'b0, 32'h100, 0);
    do_req(1'b0, 32'h104, 0);
    do_req(1'b1, 32'h108, 32'hDEADBEEF);
    do_req(1'b0, 32'h500, 0);
    do_req(1'b0, 32'h100, 0);
    do_req(1'b0, 32'h000, 0);
    drain();
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, 32'(exp_hits));
    chk("miss_count", miss_count, 32'(exp_misses));
`endif

    // Reset while the refill is outstanding.
    hold = 1'b1;
    do_req(1'b0, 32'h340, 0);
    n = 0;
    while (mst != 1 && n < 100) begin @(negedge clk); n++; end
    chk("reach_refill_wait", 1'(mst == 1), 1'b1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk); #1;
    chk("rst_mid_ready", ready, 1'b1);
    chk("rst_mid_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_mid_resp_valid", resp_valid, 1'b0);
`ifdef DCACHE_STATS_EN
    chk("rst_hit_count", hit_count, 32'h0);
    chk("rst_miss_count", miss_count, 32'h0);
`endif
    reset = 1'b0; hold = 1'b0;
    clear_model();
    ref_mem = bmem;
    do_req(1'b0, 32'h104, 0);
    drain();

    // Random traffic over 4 tags x 16 sets to force hits, clean and dirty misses.
    for (int k = 0; k < 300; k++) begin
      logic [31:0] a;
      a = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      do_req(1'($urandom_range(0, 1)), a, $urandom);
    end
    drain();
`ifdef DCACHE_STATS_EN
    chk("hit_count_final", hit_count, 32'(exp_hits));
    chk("miss_count_final", miss_count, 32'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
